// File: rtl/score_keeper_pkg.sv
// ============================================================================
//  Module      : score_keeper_pkg
//  Description : Shared types and constants for the score keeper: game
//                state enumeration, winner encodings and the digit limit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package score_keeper_pkg;

    // Game state; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Winner encodings; 2'b11 is never produced
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Largest value a score digit may show on the display
    localparam int MAX_DIGIT = 9;

endpackage

`default_nettype wire

// File: rtl/score_keeper_btn_cond.sv
// ============================================================================
//  Module      : btn_cond
//  Description : Button conditioner: 2-flop synchronizer, optional debouncer
//                (enabled by defining SCORE_DEBOUNCE_EN) and a registered
//                rising-edge detector producing a single-cycle pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [1:0] r_sync;
    logic       w_level;
    logic       r_prev;
    logic       r_pulse;

    // Bring the raw asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn};
        end
    end

`ifdef SCORE_DEBOUNCE_EN
    // Counter reaches this value on the last of DEBOUNCE_CYCLES stable cycles
    localparam logic [15:0] c_db_last = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] r_db_cnt;
    logic        r_db_level;

    // Accept a new level only after it has been stable long enough; any
    // return to the current level restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt   <= 16'd0;
            r_db_level <= 1'b0;
        end else if (r_sync[1] == r_db_level) begin
            r_db_cnt   <= 16'd0;
        end else if (r_db_cnt == c_db_last) begin
            r_db_cnt   <= 16'd0;
            r_db_level <= r_sync[1];
        end else begin
            r_db_cnt   <= r_db_cnt + 16'd1;
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync[1];
`endif

    // Registered rising-edge detect: one pulse per press, none while held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_pulse <= w_level & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
//  Module      : score_keeper
//  Description : Two-player score keeper. Conditions three buttons, counts
//                points in PLAY, declares a winner at WIN_SCORE and waits
//                for a new start. Define SCORE_DEBOUNCE_EN to enable the
//                per-button debouncer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WIN_SCORE       = 9,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic       btn_start,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic       game_over
);

    // Winning total, clamped to a single display digit
    localparam logic [3:0] c_win = 4'((WIN_SCORE > MAX_DIGIT) ? MAX_DIGIT : WIN_SCORE);

    logic       w_p1;
    logic       w_p2;
    logic       w_start;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_score1;
    logic [3:0] r_score2;
    logic [1:0] r_winner;
    logic [3:0] w_score1_nxt;
    logic [3:0] w_score2_nxt;
    logic [1:0] w_winner_nxt;

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_p1 (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_p1),
        .pulse (w_p1)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_p2 (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_p2),
        .pulse (w_p2)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .pulse (w_start)
    );

    // State and score registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_score1 <= 4'd0;
            r_score2 <= 4'd0;
            r_winner <= WIN_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_score1 <= w_score1_nxt;
            r_score2 <= w_score2_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    // Next state: start has priority, simultaneous points cancel, the
    // winning point moves straight to OVER
    always_comb begin
        w_state_nxt  = r_state;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_winner_nxt = r_winner;
        case (r_state)
            IDLE, OVER: begin
                if (w_start) begin
                    w_state_nxt  = PLAY;
                    w_score1_nxt = 4'd0;
                    w_score2_nxt = 4'd0;
                    w_winner_nxt = WIN_NONE;
                end
            end
            PLAY: begin
                if (w_start) begin
                    w_score1_nxt = 4'd0;
                    w_score2_nxt = 4'd0;
                end else if (w_p1 && !w_p2 && (r_score1 < c_win)) begin
                    w_score1_nxt = r_score1 + 4'd1;
                    if ((r_score1 + 4'd1) == c_win) begin
                        w_state_nxt  = OVER;
                        w_winner_nxt = WIN_P1;
                    end
                end else if (w_p2 && !w_p1 && (r_score2 < c_win)) begin
                    w_score2_nxt = r_score2 + 4'd1;
                    if ((r_score2 + 4'd1) == c_win) begin
                        w_state_nxt  = OVER;
                        w_winner_nxt = WIN_P2;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        score1    = r_score1;
        score2    = r_score2;
        winner    = r_winner;
        game_over = (r_state == OVER);
    end

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Self-checking bench for score_keeper with a game-level
//                reference model and a queue-based scoreboard. Honours
//                SCORE_DEBOUNCE_EN for latency and glitch scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int WIN = 9;
    localparam int DBC = 16;
`ifdef SCORE_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
    localparam int LAT   = 3 + DBC;
`else
    localparam bit DB_EN = 1'b0;
    localparam int LAT   = 3;
`endif
    localparam int GAP = LAT + 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_p1 = 1'b0;
    logic       btn_p2 = 1'b0;
    logic       btn_start = 1'b0;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic       game_over;

    score_keeper #(.WIN_SCORE(WIN), .DEBOUNCE_CYCLES(DBC)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_p1    (btn_p1),
        .btn_p2    (btn_p2),
        .btn_start (btn_start),
        .score1    (score1),
        .score2    (score2),
        .winner    (winner),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         at;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] w;
        logic       go;
    } exp_t;
    exp_t q[$];

    // Reference game model: 0 idle, 1 playing, 2 over
    int m_state = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_w  = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Apply one press to the model; queue the visible result if it changes
    task automatic model_apply(input bit p1, input bit p2, input bit st, input int hold, input int at);
        int o1, o2, ow, os;
        exp_t e;
        if (DB_EN && hold < DBC) return;
        o1 = m_s1; o2 = m_s2; ow = m_w; os = m_state;
        if (st) begin
            m_state = 1; m_s1 = 0; m_s2 = 0; m_w = 0;
        end else if (m_state == 1 && (p1 != p2)) begin
            if (p1) begin
                m_s1++;
                if (m_s1 == WIN) begin m_state = 2; m_w = 1; end
            end else begin
                m_s2++;
                if (m_s2 == WIN) begin m_state = 2; m_w = 2; end
            end
        end
        if (o1 != m_s1 || o2 != m_s2 || ow != m_w || (os == 2) != (m_state == 2)) begin
            e.at = at;
            e.s1 = 4'(m_s1);
            e.s2 = 4'(m_s2);
            e.w  = 2'(m_w);
            e.go = (m_state == 2);
            q.push_back(e);
        end
    endtask

    task automatic press(input bit p1, input bit p2, input bit st, input int hold, input int gap);
        int k;
        @(negedge clk);
        k = cyc + 1;
        btn_p1 = p1; btn_p2 = p2; btn_start = st;
        model_apply(p1, p2, st, hold, k + LAT);
        repeat (hold) @(negedge clk);
        btn_p1 = 1'b0; btn_p2 = 1'b0; btn_start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, q.size(), 0);
        q.delete();
    endtask

    task automatic chk_outputs(input string name);
        chk({name, "_score1"}, int'(score1), m_s1);
        chk({name, "_score2"}, int'(score2), m_s2);
        chk({name, "_winner"}, int'(winner), m_w);
        chk({name, "_game_over"}, int'(game_over), int'(m_state == 2));
    endtask

    // Monitor: every visible output change must match the next queued result
    bit         mon_en = 1'b0;
    logic [10:0] prev = '0;
    always @(negedge clk) begin
        logic [10:0] cur;
        exp_t e;
        cur = {score1, score2, winner, game_over};
        if (mon_en) begin
            if (cur != prev) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_change: got %h expected no change at cycle %0d", cur, cyc);
                end else begin
                    e = q.pop_front();
                    chk("update_cycle", cyc, e.at);
                    chk("update_score1", int'(score1), int'(e.s1));
                    chk("update_score2", int'(score2), int'(e.s2));
                    chk("update_winner", int'(winner), int'(e.w));
                    chk("update_game_over", int'(game_over), int'(e.go));
                end
            end else if (q.size() != 0 && cyc > q[0].at) begin
                e = q.pop_front();
                checks++; failures++;
                $display("FAIL missing_update: got no change expected s1=%0d s2=%0d by cycle %0d", e.s1, e.s2, e.at);
            end
        end
        prev = cur;
    end

    initial begin
        int r, h;
        bit rnd_p1, rnd_p2, rnd_st;

        // Reset state
        repeat (3) @(negedge clk);
        chk_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Points ignored while idle, then start and three p1 points
        press(1, 0, 0, 2, GAP);
        press(0, 0, 1, 2, GAP);
        repeat (3) press(1, 0, 0, 2, GAP);
        drain("three_p1");
        chk_outputs("three_p1");

        // Simultaneous points cancel
        press(1, 1, 0, 2, GAP);
        drain("both_points");
        chk_outputs("both_points");

        // Start with a point in PLAY clears and stays in PLAY
        press(1, 0, 1, 2, GAP);
        drain("start_priority");
        chk_outputs("start_priority");

        // Held button yields exactly one point
        press(0, 1, 0, 50, GAP);
        drain("held");
        chk_outputs("held");

        // Player 2 reaches the winning score; further points ignored
        repeat (WIN - 1) press(0, 1, 0, 2, GAP);
        press(1, 0, 0, 2, GAP);
        press(0, 1, 0, 2, GAP);
        drain("p2_wins");
        chk_outputs("p2_wins");

        // Start from OVER clears everything
        press(0, 0, 1, 3, GAP);
        press(1, 0, 0, 2, GAP);
        drain("restart");
        chk_outputs("restart");

`ifdef SCORE_DEBOUNCE_EN
        // Short glitches rejected, clean press accepted
        press(1, 0, 0, 5, GAP);
        press(1, 0, 0, 5, GAP);
        press(1, 0, 0, 20, GAP);
        drain("debounce");
        chk_outputs("debounce");
`endif

        // Reset mid-game at score1 = 4 with a point in flight
        while (m_s1 < 4) press(1, 0, 0, DB_EN ? 20 : 2, GAP);
        drain("pre_reset");
        chk("pre_reset_score1", int'(score1), 4);
        @(negedge clk);
        btn_p1 = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        m_state = 0; m_s1 = 0; m_s2 = 0; m_w = 0;
        chk_outputs("async_reset");
        @(negedge clk);
        btn_p1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        press(1, 0, 0, DB_EN ? 20 : 2, GAP);
        press(1, 0, 0, DB_EN ? 20 : 2, GAP);
        drain("after_reset");
        chk_outputs("after_reset");
        press(0, 0, 1, DB_EN ? 20 : 2, GAP);
        press(1, 0, 0, DB_EN ? 20 : 2, GAP);
        drain("after_reset_start");
        chk_outputs("after_reset_start");

        // Randomized play against the model
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            rnd_p1 = (r <= 3) || (r == 7) || (r == 9);
            rnd_p2 = (r >= 4 && r <= 7);
            rnd_st = (r >= 8);
            if (DB_EN)
                h = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(18, 24));
            else
                h = int'($urandom_range(1, 6));
            press(rnd_p1, rnd_p2, rnd_st, h, GAP);
        end
        drain("random");
        chk_outputs("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
